// File: rtl/capture_threshold_sequencer_if.sv
// Sample-stream input and capture-RAM write port bundle for capture_threshold_sequencer.
interface capture_threshold_sequencer_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;

  // Upstream datapath drives samples and observes the RAM write port.
  modport master (
    output in_valid, in_data,
    input  cap_we, cap_addr, cap_data
  );

  // Sequencer consumes samples and drives the RAM write port.
  modport slave (
    input  in_valid, in_data,
    output cap_we, cap_addr, cap_data
  );
endinterface

// File: rtl/capture_threshold_sequencer.sv
// Snapshot capture sequencer: arm, optional pre-trigger fill, threshold trigger,
// fixed post-trigger write count, then hold done and report the trigger address.
// Optional feature macro: CAPTURE_PRETRIG_EN (pre-trigger fill and circular
// writes while waiting). Without it the trigger sample lands at address 0.
module capture_threshold_sequencer #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned PRE_SAMPLES = 64
) (
  input  logic                        user_clk,
  input  logic                        user_rst_n,
  input  logic [31:0]                 thresh_word,
  input  logic                        arm,
  capture_threshold_sequencer_if.slave smp,
  output logic [ADDR_W-1:0]           trig_addr,
  output logic                        cap_done,
  output logic                        busy,
  output logic [31:0]                 cap_count
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
`ifdef CAPTURE_PRETRIG_EN
  localparam int unsigned POST_INIT = DEPTH - PRE_SAMPLES - 1;
  localparam int unsigned PRE_LAST  = (PRE_SAMPLES == 0) ? 0 : PRE_SAMPLES - 1;
`else
  localparam int unsigned POST_INIT = DEPTH - 1;
  localparam int unsigned unused_pre_samples = PRE_SAMPLES;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef CAPTURE_PRETRIG_EN
    S_PREFILL,
`endif
    S_WAIT_TRIG,
    S_POST,
    S_DONE
  } state_t;

  state_t                    state_q;
  logic signed [DATA_W-1:0]  thr_q;
  logic [ADDR_W-1:0]         addr_q;
  logic [ADDR_W-1:0]         post_cnt_q;
`ifdef CAPTURE_PRETRIG_EN
  logic [ADDR_W-1:0]         pre_cnt_q;
`endif

  logic run_en;
  logic below_thr;
  logic unused_thresh_bits;

  // Run enable, strict signed trigger compare, and the reserved threshold bits.
  assign run_en             = thresh_word[31];
  assign below_thr          = $signed(smp.in_data) < thr_q;
  assign unused_thresh_bits = ^thresh_word[30:16];

  // Capture sequencer: state, write port, trigger address, done and counters.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q      <= S_IDLE;
      thr_q        <= '0;
      addr_q       <= '0;
      post_cnt_q   <= '0;
`ifdef CAPTURE_PRETRIG_EN
      pre_cnt_q    <= '0;
`endif
      smp.cap_we   <= 1'b0;
      smp.cap_addr <= '0;
      smp.cap_data <= '0;
      trig_addr    <= '0;
      cap_done     <= 1'b0;
      busy         <= 1'b0;
      cap_count    <= '0;
    end else begin
      smp.cap_we <= 1'b0;
      if (!run_en) begin
        // Disable overrides everything, including a simultaneous arm.
        state_q  <= S_IDLE;
        cap_done <= 1'b0;
        busy     <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (arm) begin
              thr_q    <= DATA_W'($signed(thresh_word[15:0]));
              addr_q   <= '0;
              cap_done <= 1'b0;
              busy     <= 1'b1;
`ifdef CAPTURE_PRETRIG_EN
              pre_cnt_q <= '0;
              state_q   <= (PRE_SAMPLES == 0) ? S_WAIT_TRIG : S_PREFILL;
`else
              state_q   <= S_WAIT_TRIG;
`endif
            end
          end
`ifdef CAPTURE_PRETRIG_EN
          S_PREFILL: begin
            if (smp.in_valid) begin
              smp.cap_we   <= 1'b1;
              smp.cap_addr <= addr_q;
              smp.cap_data <= smp.in_data;
              addr_q       <= addr_q + ADDR_W'(1);
              pre_cnt_q    <= pre_cnt_q + ADDR_W'(1);
              if (pre_cnt_q == ADDR_W'(PRE_LAST)) begin
                state_q <= S_WAIT_TRIG;
              end
            end
          end
          S_WAIT_TRIG: begin
            if (smp.in_valid) begin
              smp.cap_we   <= 1'b1;
              smp.cap_addr <= addr_q;
              smp.cap_data <= smp.in_data;
              addr_q       <= addr_q + ADDR_W'(1);
              if (below_thr) begin
                trig_addr  <= addr_q;
                post_cnt_q <= ADDR_W'(POST_INIT);
                state_q    <= S_POST;
              end
            end
          end
`else
          S_WAIT_TRIG: begin
            // Only the trigger sample is written; it always lands at address 0.
            if (smp.in_valid && below_thr) begin
              smp.cap_we   <= 1'b1;
              smp.cap_addr <= '0;
              smp.cap_data <= smp.in_data;
              addr_q       <= ADDR_W'(1);
              trig_addr    <= '0;
              post_cnt_q   <= ADDR_W'(POST_INIT);
              state_q      <= S_POST;
            end
          end
`endif
          S_POST: begin
            if (post_cnt_q == '0) begin
              // Finish one cycle after the final write pulse.
              state_q   <= S_DONE;
              cap_done  <= 1'b1;
              busy      <= 1'b0;
              cap_count <= cap_count + 32'd1;
            end else if (smp.in_valid) begin
              smp.cap_we   <= 1'b1;
              smp.cap_addr <= addr_q;
              smp.cap_data <= smp.in_data;
              addr_q       <= addr_q + ADDR_W'(1);
              post_cnt_q   <= post_cnt_q - ADDR_W'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_threshold_sequencer.sv
// Directed bench for capture_threshold_sequencer; expectations follow the
// CAPTURE_PRETRIG_EN setting of the build.
module tb_capture_threshold_sequencer;

  localparam int DEPTH = 1024;
`ifdef CAPTURE_PRETRIG_EN
  localparam bit PRETRIG = 1'b1;
  localparam int PRE_N   = 64;
  localparam int POST_N  = 959;
`else
  localparam bit PRETRIG = 1'b0;
  localparam int PRE_N   = 0;
  localparam int POST_N  = 1023;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] thresh_word = 32'h0;
  logic        arm = 1'b0;
  logic [9:0]  trig_addr;
  logic        cap_done;
  logic        busy;
  logic [31:0] cap_count;

  capture_threshold_sequencer_if #(.DATA_W(16), .ADDR_W(10)) bus ();

  capture_threshold_sequencer #(
    .DATA_W(16), .ADDR_W(10), .PRE_SAMPLES(64)
  ) dut (
    .user_clk    (clk),
    .user_rst_n  (rst_n),
    .thresh_word (thresh_word),
    .arm         (arm),
    .smp         (bus),
    .trig_addr   (trig_addr),
    .cap_done    (cap_done),
    .busy        (busy),
    .cap_count   (cap_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          wr_count = 0;
  int          last_addr = 0;
  logic [15:0] mem [0:DEPTH-1];
  bit          hit [0:DEPTH-1];

  // Record every RAM write seen on the capture port.
  always @(negedge clk) begin
    if (bus.cap_we === 1'b1) begin
      wr_count++;
      last_addr = int'(bus.cap_addr);
      mem[bus.cap_addr] = bus.cap_data;
      hit[bus.cap_addr] = 1'b1;
    end
  end

  task automatic clear_log();
    wr_count  = 0;
    last_addr = 0;
    for (int a = 0; a < DEPTH; a++) begin
      mem[a] = 16'h0;
      hit[a] = 1'b0;
    end
  endtask

  function automatic int hit_total();
    int t = 0;
    for (int a = 0; a < DEPTH; a++) if (hit[a]) t++;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [15:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
    tick();
  endtask

  task automatic do_arm(input logic [31:0] tw);
    thresh_word  = tw;
    arm          = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data  = 16'h0;
    #23;
    n_checks++; if (bus.cap_we !== 1'b0) begin n_fail++; $display("FAIL reset_cap_we: got %b want 0", bus.cap_we); end
    n_checks++; if (bus.cap_addr !== 10'd0) begin n_fail++; $display("FAIL reset_cap_addr: got %0d want 0", bus.cap_addr); end
    n_checks++; if (trig_addr !== 10'd0) begin n_fail++; $display("FAIL reset_trig_addr: got %0d want 0", trig_addr); end
    n_checks++; if ({cap_done, busy} !== 2'b00) begin n_fail++; $display("FAIL reset_done_busy: got %b want 00", {cap_done, busy}); end
    n_checks++; if (cap_count !== 32'd0) begin n_fail++; $display("FAIL reset_cap_count: got %0d want 0", cap_count); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_no_trigger();
    clear_log();
    do_arm(32'h8000_8000);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ramp_busy_rise: got %b want 1", busy); end
    for (int i = 0; i < 1100; i++) send(1'b1, 16'(i));
    n_checks++; if (wr_count !== (PRETRIG ? 1100 : 0)) begin n_fail++; $display("FAIL ramp_writes: got %0d want %0d", wr_count, PRETRIG ? 1100 : 0); end
    n_checks++; if (last_addr !== (PRETRIG ? 75 : 0)) begin n_fail++; $display("FAIL ramp_wrap_addr: got %0d want %0d", last_addr, PRETRIG ? 75 : 0); end
    n_checks++; if (mem[75] !== (PRETRIG ? 16'd1099 : 16'd0)) begin n_fail++; $display("FAIL ramp_wrap_data: got %0d", mem[75]); end
    n_checks++; if (hit_total() !== (PRETRIG ? DEPTH : 0)) begin n_fail++; $display("FAIL ramp_coverage: got %0d", hit_total()); end
    n_checks++; if ({busy, cap_done} !== 2'b10) begin n_fail++; $display("FAIL ramp_busy_done: got %b want 10", {busy, cap_done}); end
    thresh_word = 32'h0000_8000;
    send(1'b0, 16'h0);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ramp_disable_busy: got %b want 0", busy); end
  endtask

  task automatic test_trigger();
    int exp_trig;
    int exp_last;
    int last_i;
    exp_trig = PRETRIG ? 300 : 0;
    exp_last = (exp_trig + POST_N) % DEPTH;
    last_i   = 300 + POST_N;
    clear_log();
    do_arm(32'h8000_FFFB);
    for (int i = 0; i <= last_i; i++) send(1'b1, (i == 300) ? 16'hFFFA : 16'h0000);
    n_checks++; if (bus.cap_we !== 1'b1 || int'(bus.cap_addr) !== exp_last) begin n_fail++; $display("FAIL trig_final_write: we=%b addr=%0d want 1/%0d", bus.cap_we, bus.cap_addr, exp_last); end
    n_checks++; if (cap_done !== 1'b0) begin n_fail++; $display("FAIL trig_done_early: got %b want 0", cap_done); end
    send(1'b1, 16'hFFFA);
    n_checks++; if ({cap_done, busy, bus.cap_we} !== 3'b100) begin n_fail++; $display("FAIL trig_done_rise: done/busy/we got %b want 100", {cap_done, busy, bus.cap_we}); end
    n_checks++; if (cap_count !== 32'd1) begin n_fail++; $display("FAIL trig_count: got %0d want 1", cap_count); end
    for (int i = 0; i < 4; i++) send(1'b1, 16'hFFFA);
    n_checks++; if (int'(trig_addr) !== exp_trig) begin n_fail++; $display("FAIL trig_addr: got %0d want %0d", trig_addr, exp_trig); end
    n_checks++; if (wr_count !== (PRETRIG ? 301 + POST_N : 1 + POST_N)) begin n_fail++; $display("FAIL trig_writes: got %0d", wr_count); end
    n_checks++; if (mem[exp_trig] !== 16'hFFFA) begin n_fail++; $display("FAIL trig_sample: got %h want fffa", mem[exp_trig]); end
    n_checks++; if (hit_total() !== DEPTH) begin n_fail++; $display("FAIL trig_coverage: got %0d want %0d", hit_total(), DEPTH); end
  endtask

  task automatic test_equal_gapped();
    int exp_trig;
    int exp_last;
    int last_i;
    exp_trig = PRETRIG ? 101 : 0;
    exp_last = (exp_trig + POST_N) % DEPTH;
    last_i   = 101 + POST_N;
    clear_log();
    do_arm(32'h8000_FFFB);
    n_checks++; if ({busy, cap_done} !== 2'b10) begin n_fail++; $display("FAIL rearm_busy_done: got %b want 10", {busy, cap_done}); end
    for (int i = 0; i < last_i; i++) begin
      send(1'b1, (i == 100) ? 16'hFFFB : (i == 101) ? 16'hFFFA : 16'h0000);
      send(1'b0, 16'hFFFA);
    end
    send(1'b1, 16'h0000);
    n_checks++; if (bus.cap_we !== 1'b1 || int'(bus.cap_addr) !== exp_last || cap_done !== 1'b0) begin n_fail++; $display("FAIL gap_final_write: we=%b addr=%0d done=%b want 1/%0d/0", bus.cap_we, bus.cap_addr, cap_done, exp_last); end
    send(1'b0, 16'hFFFA);
    n_checks++; if (cap_done !== 1'b1 || cap_count !== 32'd2) begin n_fail++; $display("FAIL gap_done: done=%b count=%0d want 1/2", cap_done, cap_count); end
    n_checks++; if (int'(trig_addr) !== exp_trig) begin n_fail++; $display("FAIL gap_trig_addr: got %0d want %0d", trig_addr, exp_trig); end
    n_checks++; if (mem[exp_trig] !== 16'hFFFA) begin n_fail++; $display("FAIL gap_trig_sample: got %h want fffa", mem[exp_trig]); end
    n_checks++; if (wr_count !== (PRETRIG ? 102 + POST_N : 1 + POST_N)) begin n_fail++; $display("FAIL gap_writes: got %0d", wr_count); end
  endtask

  task automatic test_disable();
    int wc;
    clear_log();
    do_arm(32'h8000_FFFB);
    for (int i = 0; i < 81; i++) send(1'b1, (i == 70) ? 16'hFFFA : 16'h0000);
    thresh_word = 32'h0000_FFFB;
    arm = 1'b1;
    send(1'b1, 16'h0000);
    arm = 1'b0;
    n_checks++; if ({bus.cap_we, busy, cap_done} !== 3'b000) begin n_fail++; $display("FAIL dis_outputs: we/busy/done got %b want 000", {bus.cap_we, busy, cap_done}); end
    n_checks++; if (cap_count !== 32'd2) begin n_fail++; $display("FAIL dis_count: got %0d want 2", cap_count); end
    wc = wr_count;
    for (int i = 0; i < 5; i++) send(1'b1, 16'hFFFA);
    n_checks++; if (wr_count !== wc) begin n_fail++; $display("FAIL dis_no_writes: got %0d want %0d", wr_count, wc); end
    n_checks++; if (int'(trig_addr) !== (PRETRIG ? 70 : 0)) begin n_fail++; $display("FAIL dis_trig_addr: got %0d", trig_addr); end
  endtask

  task automatic test_thresh_change();
    int wc;
    clear_log();
    do_arm(32'h8000_FFFB);
    thresh_word = 32'h8000_0064;
    wc = wr_count;
    for (int i = 0; i < PRE_N; i++) send(1'b1, 16'h0000);
    send(1'b1, 16'd50);
    for (int i = 0; i < 3; i++) send(1'b1, 16'h0000);
    n_checks++; if (wr_count - wc !== (PRETRIG ? PRE_N + 4 : 0)) begin n_fail++; $display("FAIL thr_latched_writes: got %0d", wr_count - wc); end
    n_checks++; if ({busy, cap_done} !== 2'b10) begin n_fail++; $display("FAIL thr_latched_state: got %b want 10", {busy, cap_done}); end
    n_checks++; if (int'(trig_addr) !== (PRETRIG ? 70 : 0)) begin n_fail++; $display("FAIL thr_latched_trig: got %0d", trig_addr); end
    thresh_word = 32'h0000_0064;
    send(1'b0, 16'h0);
    do_arm(32'h8000_0064);
    for (int i = 0; i < PRE_N; i++) send(1'b1, 16'h0000);
    send(1'b1, 16'd50);
    n_checks++; if (bus.cap_we !== 1'b1 || int'(bus.cap_addr) !== PRE_N || int'(trig_addr) !== PRE_N) begin n_fail++; $display("FAIL thr_new_trigger: we=%b addr=%0d trig=%0d want 1/%0d/%0d", bus.cap_we, bus.cap_addr, trig_addr, PRE_N, PRE_N); end
    thresh_word = 32'h0000_0064;
    send(1'b0, 16'h0);
  endtask

  task automatic test_reset_mid();
    do_arm(32'h8000_FFFB);
    for (int i = 0; i < PRE_N; i++) send(1'b1, 16'h0000);
    send(1'b1, 16'hFFFA);
    for (int i = 0; i < 5; i++) send(1'b1, 16'h1234);
    n_checks++; if (bus.cap_we !== 1'b1 || bus.cap_data !== 16'h1234 || busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: we=%b data=%h busy=%b", bus.cap_we, bus.cap_data, busy); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.cap_we, cap_done, busy} !== 3'b000 || bus.cap_addr !== 10'd0 || bus.cap_data !== 16'd0) begin n_fail++; $display("FAIL rstmid_port: we/done/busy=%b addr=%0d data=%h", {bus.cap_we, cap_done, busy}, bus.cap_addr, bus.cap_data); end
    n_checks++; if (trig_addr !== 10'd0 || cap_count !== 32'd0) begin n_fail++; $display("FAIL rstmid_regs: trig=%0d count=%0d want 0/0", trig_addr, cap_count); end
    #10;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) send(1'b1, 16'hFFFA);
    n_checks++; if ({bus.cap_we, busy} !== 2'b00) begin n_fail++; $display("FAIL rstmid_idle: we/busy got %b want 00", {bus.cap_we, busy}); end
  endtask

  initial begin
    test_reset();
    test_no_trigger();
    test_trigger();
    test_equal_gapped();
    test_disable();
    test_thresh_change();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/capture_threshold_sequencer.md
# capture_threshold_sequencer

Sequences one photon-pulse snapshot capture on the readout sample stream, using the software threshold word delivered by the capture threshold register (user_data_out of the OPB-to-fabric register, already synchronous to user_clk). After software arms it, it writes samples into a circular capture RAM, triggers when a sample falls strictly below the signed threshold, keeps writing a fixed number of post-trigger samples, then stops and reports the trigger address. It sits between the channel-select/phase datapath and the snapshot BRAM write port.

## Interface
Parameters:
- DATA_W, 16, sample width (signed two's complement)
- ADDR_W, 10, capture RAM address width; DEPTH = 2^ADDR_W
- PRE_SAMPLES, 64, pre-trigger samples retained; legal range 0 .. DEPTH-1

Ports:
- user_clk  in  1  single clock for all logic
- user_rst_n  in  1  asynchronous, active-low reset
- thresh_word  in  32  [15:0] signed threshold (sign-extended/truncated to DATA_W), [31] run enable, [30:16] reserved/ignored
- arm  in  1  one-cycle arm request
- in_valid  in  1  sample strobe
- in_data  in  DATA_W  signed sample
- cap_we  out  1  capture RAM write enable
- cap_addr  out  ADDR_W  capture RAM write address
- cap_data  out  DATA_W  capture RAM write data
- trig_addr  out  ADDR_W  address holding the trigger sample
- cap_done  out  1  capture complete, held until next arm or disable
- busy  out  1  high in PREFILL, WAIT_TRIG, POST
- cap_count  out  32  completed captures since reset, wraps

## Operation
- States: IDLE, PREFILL, WAIT_TRIG, POST, DONE.
- IDLE: arm=1 and run enable=1 -> latch thresh_word[15:0] into thr_q, clear write address to 0, clear cap_done -> PREFILL. Threshold changes after arming are ignored until the next arm.
- PREFILL: every valid sample is written at cap_addr, address increments mod DEPTH; no trigger evaluation. After PRE_SAMPLES writes -> WAIT_TRIG (PRE_SAMPLES=0: skip straight to WAIT_TRIG).
- WAIT_TRIG: every valid sample is written circularly; if in_data < thr_q (signed, strict; equality does not trigger) that sample is the trigger: trig_addr <= its write address -> POST with post counter = DEPTH-PRE_SAMPLES-1.
- POST: each valid sample is written and decrements the counter; when the counter reaches 0 after a write (or immediately if it starts at 0) -> DONE, cap_count increments.
- DONE: no writes; cap_done=1. arm with run enable=1 -> rearm exactly as from IDLE.
- run enable=0 in any state -> IDLE next cycle, cap_done cleared, no further writes; disable wins over a simultaneous arm.
- arm in PREFILL/WAIT_TRIG/POST is ignored.
- in_valid=0 cycles are gaps: no write, no count, no trigger.
- Net result: RAM holds PRE_SAMPLES samples before trig_addr and DEPTH-PRE_SAMPLES-1 after it, wrapping mod DEPTH.

## Timing
- Write path is registered: sample with in_valid at cycle n gives cap_we/cap_addr/cap_data at cycle n+1.
- Trigger compare uses the same cycle-n sample; trig_addr is valid from cycle n+1 and stable until next arm.
- cap_done and the cap_count increment appear the cycle after the final cap_we pulse.
- busy rises the cycle after an accepted arm; falls with cap_done rise or one cycle after disable.
- Reset: state IDLE; cap_we, cap_addr, cap_data, trig_addr, cap_done, busy = 0; cap_count = 0; thr_q = 0. Reset mid-capture abandons the capture immediately.

## Configuration
- CAPTURE_PRETRIG_EN defined: behaviour as above (PREFILL and circular writes in WAIT_TRIG).
- Undefined: PRE_SAMPLES ignored; arm goes to WAIT_TRIG with no writes; trigger sample written at address 0, trig_addr = 0 always, POST writes DEPTH-1 further samples to addresses 1..DEPTH-1; PREFILL state and its counter are not built.

## Test plan
- Defaults, macro defined: arm, feed ramp 0,1,2..., threshold 0x8000 never hit -> writes wrap mod 1024, busy stays 1, cap_done 0.
- Threshold -5, stream 0 except sample -6 at index 300 -> trig_addr = 300, exactly 959 further writes ending at address 235, cap_done one cycle after, cap_count = 1.
- Sample equal to threshold (-5), then -6 -> only the -6 sample triggers; in_valid gapped 50% -> counts, addresses unchanged by gaps.
- Disable (bit 31 low) mid-POST with simultaneous arm -> IDLE next cycle, no further cap_we, cap_done 0, cap_count unchanged.
- Threshold word changed after arm from -5 to 100 -> sample 50 does not trigger; after next arm it does.
- Macro undefined: trigger at any point -> trig_addr 0, addresses 0..1023 written once, cap_done; assert user_rst_n low mid-capture -> all outputs 0 asynchronously.
